// File: rtl/fp_special_case_pipe.sv
// IEEE-754 operand classifier / special-result generator for FP mul and add, with a LATENCY-deep valid/ready pipeline.
// Optional build macro FP_SPECIAL_STICKY_FLAGS_EN adds clear_sticky / sticky_status accumulation.
module fp_special_case_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 1,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_mode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         zero_flag,
  output logic         denorm_flag,
  output logic         inf_flag,
  output logic         nan_flag,
  output logic         invalid_flag,
  output logic         special_flag,
  output logic [W-1:0] special_result
`ifdef FP_SPECIAL_STICKY_FLAGS_EN
  ,
  input  logic         clear_sticky,
  output logic [3:0]   sticky_status
`endif
);

  localparam int P = W + 6;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             nan_a, nan_b, inf_a, inf_b, den_a, den_b, zero_a, zero_b;
  logic [W-1:0]     res;
  logic             special, invalid;
  logic [P-1:0]     stage_in;
  logic             adv;

  logic             valid_reg [LATENCY];
  logic [P-1:0]     data_reg  [LATENCY];

  assign sign_a = in_a[W-1];
  assign sign_b = in_b[W-1];
  assign exp_a  = in_a[W-2:MAN_W];
  assign exp_b  = in_b[W-2:MAN_W];
  assign man_a  = in_a[MAN_W-1:0];
  assign man_b  = in_b[MAN_W-1:0];

  // zero_x covers both true zeros and denormals (denormals-are-zero)
  assign nan_a  = (&exp_a) & (|man_a);
  assign nan_b  = (&exp_b) & (|man_b);
  assign inf_a  = (&exp_a) & ~(|man_a);
  assign inf_b  = (&exp_b) & ~(|man_b);
  assign den_a  = ~(|exp_a) & (|man_a);
  assign den_b  = ~(|exp_b) & (|man_b);
  assign zero_a = ~(|exp_a);
  assign zero_b = ~(|exp_b);

  always_comb begin
    res     = '0;
    special = 1'b0;
    invalid = 1'b0;
    if (!op_mode) begin
      if (nan_a | nan_b) begin
        res = QNAN; special = 1'b1;
      end else if ((inf_a & zero_b) | (zero_a & inf_b)) begin
        res = QNAN; special = 1'b1; invalid = 1'b1;
      end else if (inf_a | inf_b) begin
        res = {sign_a ^ sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; special = 1'b1;
      end else if (zero_a | zero_b) begin
        res = {sign_a ^ sign_b, {(W-1){1'b0}}}; special = 1'b1;
      end
    end else begin
      if (nan_a | nan_b) begin
        res = QNAN; special = 1'b1;
      end else if (inf_a & inf_b & (sign_a ^ sign_b)) begin
        res = QNAN; special = 1'b1; invalid = 1'b1;
      end else if (inf_a) begin
        res = in_a; special = 1'b1;
      end else if (inf_b) begin
        res = in_b; special = 1'b1;
      end else if (zero_a & zero_b) begin
        res = {sign_a & sign_b, {(W-1){1'b0}}}; special = 1'b1;
      end else if (zero_a) begin
        res = in_b; special = 1'b1;
      end else if (zero_b) begin
        res = in_a; special = 1'b1;
      end
    end
  end

  // Bubbles carry an all-zero payload so idle outputs read as zero
  assign stage_in = in_valid ? {zero_a | zero_b, den_a | den_b, inf_a | inf_b, nan_a | nan_b,
                                invalid, special, res} : '0;

  assign adv      = out_ready | ~valid_reg[LATENCY-1];
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
        data_reg[i]  <= '0;
      end
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      data_reg[0]  <= stage_in;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[LATENCY-1];
  assign {zero_flag, denorm_flag, inf_flag, nan_flag, invalid_flag, special_flag,
          special_result} = data_reg[LATENCY-1];

`ifdef FP_SPECIAL_STICKY_FLAGS_EN
  // Clear has priority over the accumulation of a simultaneous transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_status <= 4'b0000;
    end else if (clear_sticky) begin
      sticky_status <= 4'b0000;
    end else if (out_valid & out_ready) begin
      sticky_status <= sticky_status | {invalid_flag, nan_flag, inf_flag, denorm_flag};
    end
  end
`endif

endmodule
